instb_fetch_reader: RTL

//   Read-side master for the instruction-buffer SRAM (port B: enb/addrb/doutb, 1-cycle read latency).
//   On a start command it fetches inst_num consecutive DW-bit instruction words from start_addr.
//   It streams them to the instruction decoder over a valid/ready interface, with full backpressure.
//   A 2-entry output FIFO absorbs the SRAM latency; sustains 1 instruction/cycle while inst_ready=1.

---
 rtl/instb_fetch_reader.sv | 118 +++++++++++
 1 files changed

// File: rtl/instb_fetch_reader.sv
// Read-side master for the instruction-buffer SRAM: fetches inst_num words from start_addr
// and streams them over valid/ready through a 2-entry FIFO that hides the 1-cycle read latency.
module instb_fetch_reader #(
  parameter int AW = 12,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   inst_num,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic          enb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] doutb,
  output logic          inst_valid,
  output logic [DW-1:0] inst_data,
  input  logic          inst_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE_ZERO} state_t;

  state_t        state;
  logic [AW:0]   num_q;
  logic [AW:0]   issued_cnt;
  logic [AW:0]   recv_cnt;
  logic          rd_pending;
  logic [DW-1:0] fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_cnt;
  logic          pop;
  logic          push;
  logic [2:0]    credit_sum;

  assign inst_valid = (fifo_cnt != 2'd0);
  assign inst_data  = fifo_mem[rd_ptr];
  assign pop        = inst_valid & inst_ready;
  assign push       = rd_pending & ~flush;

  // Reserve a FIFO slot for every read in flight; a same-cycle pop frees one, keeping 1 word/cycle.
  assign credit_sum = {1'b0, fifo_cnt} + {2'b00, rd_pending} - {2'b00, pop};
  assign enb        = (state == FETCH) & ~flush & (credit_sum < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      addrb       <= '0;
      num_q       <= '0;
      issued_cnt  <= '0;
      recv_cnt    <= '0;
      rd_pending  <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else if (flush) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_pending <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
    end else begin
      done       <= 1'b0;
      rd_pending <= enb;
      if (push) begin
        fifo_mem[wr_ptr] <= doutb;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        recv_cnt <= recv_cnt + 1'b1;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      if (enb) begin
        addrb      <= addrb + 1'b1;
        issued_cnt <= issued_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            addrb      <= start_addr;
            num_q      <= inst_num;
            issued_cnt <= '0;
            recv_cnt   <= '0;
            if (inst_num == '0) begin
              state <= DONE_ZERO;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (enb && (issued_cnt + 1'b1 == num_q)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (recv_cnt + 1'b1 == num_q)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE_ZERO: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule
